systolic_ctrl: RTL and testbench
================================

# systolic_ctrl

Sequencing controller for an N×N output-stationary systolic array built from `pe` processing elements. On `start` it:
- clears the PE accumulators;
- streams K skewed operand beats from the per-row A buffers and per-column B buffers;
- waits for the wavefront to drain;
- hands the N result rows to downstream logic under a valid/ready handshake.

It sits between the operand buffers and the array wrapper, and is the only source of the array's clear signal.

## Interface
- `ARRAY_N`, 4: array dimension N (rows = columns).
- `K_W`, 8: width of the inner-dimension length and of the buffer addresses.
- `DRAIN_EXTRA`, 2: cycles beyond N-1 needed for the last product to land in PE(N-1,N-1). Covers the buffer read latency and the result register.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: start request; sampled only in IDLE.
- `k_len` in K_W: inner dimension K; captured on accepted `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at completion.
- `pe_clr_n` out 1: synchronous active-low clear, driven to every PE `rst_n`.
- `a_rd_en` out N: per-row A buffer read enable.
- `a_rd_addr` out N*K_W: packed per-row A read address; row i occupies bits [i*K_W +: K_W].
- `b_rd_en` out N: per-column B buffer read enable.
- `b_rd_addr` out N*K_W: packed per-column B read address.
- `res_valid` out 1: result row available.
- `res_row` out clog2(N): index of the row being presented.
- `res_ready` in 1: downstream accepts the row.

## Operation
States and transitions:
- **IDLE**: `start`=1 → CLEAR; latch `k_len`.
- **CLEAR**: one cycle, `pe_clr_n`=0. Then FEED if K≠0, else READ; K=0 yields all-zero results.
- **FEED**: feed counter t = 0..K+N-2, i.e. K+N-1 cycles.
  - Row i: `a_rd_en[i]` = (i ≤ t < i+K); address t-i when enabled, else 0.
  - Columns use the same rule on the `b_*` outputs.
  - At t = K+N-2 → DRAIN.
- **DRAIN**: N-1+DRAIN_EXTRA cycles, all read enables low → READ.
- **READ**: `res_valid`=1, `res_row`=r starting at 0.
  - r increments on `res_valid`&`res_ready`.
  - Accepting r = N-1 → DONE.
  - `res_ready` low holds r indefinitely.
- **DONE**: `done`=1 for one cycle → IDLE.

Array data-path rules:
- The array wrapper forces west/north inputs to zero whenever the matching enable, delayed by the buffer latency, is low. A zero input adds 0×0 to the accumulator, so results stay stable through DRAIN and READ.
- `pe_clr_n` is high in every state except CLEAR and during reset, so results persist until the next start.
- `start` outside IDLE is ignored; `k_len` changes after capture are ignored.

## Timing
- Reset values: state IDLE; `busy`, `done`, `res_valid`, `a_rd_en`, `b_rd_en` = 0; all addresses 0; `res_row` 0.
- During reset `pe_clr_n` = 0; the array is cleared while reset is held.
- Reset asserted mid-operation returns to IDLE immediately. No `done` is produced; the next run starts with CLEAR.
- `start` accepted at edge 0 → CLEAR in cycle 1 → FEED from cycle 2.
- With `res_ready` tied high, `done` is high in cycle K+3N+DRAIN_EXTRA.
  - K=0: `done` is high in cycle N+2.
- All outputs are registered or decoded from registered state; no combinational path from `res_ready` to outputs other than the row increment.
- `start` may be asserted in the cycle after `done`, with no dead cycle required.

## Configuration
- `SYSTOLIC_CTRL_PERF_EN` defined:
  - Adds output `perf_cycles` (32 bits), which counts cycles with `busy`=1 for the most recent operation.
  - It clears on accepted `start`, freezes in DONE, saturates at all-ones, and resets to 0.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

## Structure
- Package `systolic_pkg`: the state enum (IDLE, CLEAR, FEED, DRAIN, READ, DONE), the default `ARRAY_N`/`K_W` constants, and the helper for the `res_row` width.
- Sub-module `skew_gen`: combinational. Takes t and K; produces the N-bit enable mask and the packed addresses. Instantiated once each for A and B.

## Test plan
- N=4, K=3, `res_ready`=1, `start` at cycle 0:
  - `pe_clr_n` low only in cycle 1.
  - `a_rd_en[3]` high in cycles 5–7 with addresses 0,1,2.
  - `res_row` 0..3 in cycles 13–16.
  - `done` in cycle 17.
- Same run with `res_ready` low for 3 cycles at row 2: `res_row` holds 2 and `done` slips by exactly 3 cycles.
- K=0: no read enables ever asserted; `done` in cycle 6; `busy` in cycles 1–6.
- `rst_n` pulsed low during FEED at t=2:
  - All enables drop asynchronously; state IDLE; `pe_clr_n`=0 while in reset.
  - A following `start` completes normally.
- `start` held high continuously:
  - Back-to-back operations with IDLE for one cycle between them.
  - `start` pulses during `busy` have no effect.
- With `SYSTOLIC_CTRL_PERF_EN`, N=4, K=3: `perf_cycles` = 17 after `done` and unchanged in IDLE.

Source files
------------

// File: rtl/systolic_ctrl_pkg.sv
// Shared types and constants for the systolic array sequencing controller.
package systolic_pkg;

    localparam int ARRAY_N_DEF = 4;
    localparam int K_W_DEF     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_READ,
        ST_DONE
    } state_e;

    // A 1x1 array still needs a one-bit row index.
    function automatic int row_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// Controller-side bundle: start/length, operand-buffer reads, PE clear and result handshake.
// Carries perf_cycles only when SYSTOLIC_CTRL_PERF_EN is defined.
interface systolic_ctrl_if #(
    parameter int ARRAY_N = systolic_pkg::ARRAY_N_DEF,
    parameter int K_W     = systolic_pkg::K_W_DEF
) ();
    localparam int ROW_W = systolic_pkg::row_w(ARRAY_N);

    logic                     start;
    logic [K_W-1:0]           k_len;
    logic                     busy;
    logic                     done;
    logic                     pe_clr_n;
    logic [ARRAY_N-1:0]       a_rd_en;
    logic [ARRAY_N*K_W-1:0]   a_rd_addr;
    logic [ARRAY_N-1:0]       b_rd_en;
    logic [ARRAY_N*K_W-1:0]   b_rd_addr;
    logic                     res_valid;
    logic [ROW_W-1:0]         res_row;
    logic                     res_ready;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0]              perf_cycles;
`endif

    modport master (
        input  start, k_len, res_ready,
        output busy, done, pe_clr_n, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
               res_valid, res_row
`ifdef SYSTOLIC_CTRL_PERF_EN
        , output perf_cycles
`endif
    );

    modport slave (
        output start, k_len, res_ready,
        input  busy, done, pe_clr_n, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
               res_valid, res_row
`ifdef SYSTOLIC_CTRL_PERF_EN
        , input perf_cycles
`endif
    );

endinterface

// File: rtl/systolic_ctrl_skew_gen.sv
// Combinational skew decoder: lane i reads element t-i while i <= t < i+K, else idles at address 0.
module skew_gen
    import systolic_pkg::*;
#(
    parameter int ARRAY_N = ARRAY_N_DEF,
    parameter int K_W     = K_W_DEF
) (
    input  logic                   active,
    input  logic [K_W:0]           t,
    input  logic [K_W-1:0]         k,
    output logic [ARRAY_N-1:0]     en,
    output logic [ARRAY_N*K_W-1:0] addr
);

    always_comb begin
        en   = '0;
        addr = '0;
        for (int i = 0; i < ARRAY_N; i++) begin
            // One extra bit so i+K cannot wrap at the top of the K range.
            if (active && ({1'b0, t} >= (K_W+2)'(i)) &&
                ({1'b0, t} < ((K_W+2)'(i) + {2'b00, k}))) begin
                en[i]                = 1'b1;
                addr[i*K_W +: K_W]   = K_W'(t - (K_W+1)'(i));
            end
        end
    end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an NxN output-stationary systolic array: clear, skewed feed, drain, row readout.
// Optional busy-cycle counter on perf_cycles when SYSTOLIC_CTRL_PERF_EN is defined.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int ARRAY_N     = ARRAY_N_DEF,
    parameter int K_W         = K_W_DEF,
    parameter int DRAIN_EXTRA = 2
) (
    input logic             clk,
    input logic             rst_n,
    systolic_ctrl_if.master bus
);

    localparam int                ROW_W      = row_w(ARRAY_N);
    localparam logic [K_W:0]      DRAIN_LAST = (K_W+1)'(ARRAY_N - 2 + DRAIN_EXTRA);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(ARRAY_N - 1);

    state_e           state_q, state_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [K_W:0]     cnt_q, cnt_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [K_W:0]     feed_last;
    logic             feed_active;

    // Last feed beat is t = K+N-2, when row N-1 consumes its final operand.
    assign feed_last   = {1'b0, k_q} + (K_W+1)'(ARRAY_N - 2);
    assign feed_active = (state_q == ST_FEED);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_CLEAR;
                    k_d     = bus.k_len;
                    cnt_d   = '0;
                    row_d   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_d   = '0;
                state_d = (k_q != '0) ? ST_FEED : ST_READ;
            end
            ST_FEED: begin
                if (cnt_q == feed_last) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + (K_W+1)'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = ST_READ;
                end else begin
                    cnt_d = cnt_q + (K_W+1)'(1);
                end
            end
            ST_READ: begin
                if (bus.res_ready) begin
                    if (row_q == ROW_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
        end
    end

    skew_gen #(.ARRAY_N(ARRAY_N), .K_W(K_W)) u_skew_a (
        .active (feed_active),
        .t      (cnt_q),
        .k      (k_q),
        .en     (bus.a_rd_en),
        .addr   (bus.a_rd_addr)
    );

    skew_gen #(.ARRAY_N(ARRAY_N), .K_W(K_W)) u_skew_b (
        .active (feed_active),
        .t      (cnt_q),
        .k      (k_q),
        .en     (bus.b_rd_en),
        .addr   (bus.b_rd_addr)
    );

    // Reset also holds the PEs cleared, so results never survive a reset.
    assign bus.pe_clr_n  = rst_n && (state_q != ST_CLEAR);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.res_valid = (state_q == ST_READ);
    assign bus.res_row   = row_q;

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if ((state_q == ST_IDLE) && bus.start) begin
            perf_d = '0;
        end else if ((state_q != ST_IDLE) && (perf_q != '1)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign bus.perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: cycle-level behavioural model compared every cycle, plus hand-computed timeline checks.
module tb_systolic_ctrl;

    localparam int N  = 4;
    localparam int KW = 8;
    localparam int DE = 2;

    logic clk;
    logic rst_n;
    int   cyc;
    int   c0;
    bit   rec_on;
    int   n_chk;
    int   n_pass;

    systolic_ctrl_if #(.ARRAY_N(N), .K_W(KW)) bus ();

    systolic_ctrl #(.ARRAY_N(N), .K_W(KW), .DRAIN_EXTRA(DE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Per-run timeline, indexed by cycle number relative to the accepting edge.
    bit rec_clr   [64];
    bit rec_en3   [64];
    int rec_addr3 [64];
    int rec_row   [64];
    bit rec_valid [64];
    bit rec_done  [64];
    bit rec_busy  [64];
    bit rec_anyen [64];

    // Model state: one operation described by its start-relative cycle and accepted rows.
    bit m_on;
    int m_rc, m_k, m_acc, m_rs, m_perf;

    always @(negedge clk) begin
        logic [N-1:0]    e_en;
        logic [N*KW-1:0] e_addr;
        bit              e_valid;
        bit              feeding;
        int              t;
        int              rc;
        if (!rst_n) begin
            m_on   = 0;
            m_perf = 0;
            chk("rst_busy",  bus.busy,      0);
            chk("rst_done",  bus.done,      0);
            chk("rst_clr_n", bus.pe_clr_n,  0);
            chk("rst_a_en",  bus.a_rd_en,   0);
            chk("rst_b_en",  bus.b_rd_en,   0);
            chk("rst_a_adr", bus.a_rd_addr, 0);
            chk("rst_b_adr", bus.b_rd_addr, 0);
            chk("rst_valid", bus.res_valid, 0);
            chk("rst_row",   bus.res_row,   0);
        end else begin
            e_en    = '0;
            e_addr  = '0;
            e_valid = 0;
            if (m_on) begin
                t       = m_rc - 2;
                feeding = (m_k > 0) && (t >= 0) && (t <= m_k + N - 2);
                for (int i = 0; i < N; i++) begin
                    if (feeding && t >= i && t < i + m_k) begin
                        e_en[i]             = 1'b1;
                        e_addr[i*KW +: KW]  = KW'(t - i);
                    end
                end
                e_valid = (m_rc >= m_rs) && (m_acc < N);
            end
            chk("busy",      bus.busy,      m_on);
            chk("done",      bus.done,      m_on && (m_acc == N));
            chk("pe_clr_n",  bus.pe_clr_n,  !(m_on && m_rc == 1));
            chk("a_rd_en",   bus.a_rd_en,   e_en);
            chk("b_rd_en",   bus.b_rd_en,   e_en);
            chk("a_rd_addr", bus.a_rd_addr, e_addr);
            chk("b_rd_addr", bus.b_rd_addr, e_addr);
            chk("res_valid", bus.res_valid, e_valid);
            if (e_valid) chk("res_row", bus.res_row, m_acc);
`ifdef SYSTOLIC_CTRL_PERF_EN
            chk("perf_cycles", bus.perf_cycles, m_perf);
`endif
            if (m_on) begin
                m_perf++;
                if (m_acc == N) m_on = 0;
                else begin
                    if (e_valid && bus.res_ready) m_acc++;
                    m_rc++;
                end
            end else if (bus.start) begin
                m_on   = 1;
                m_rc   = 1;
                m_k    = int'(bus.k_len);
                m_acc  = 0;
                m_perf = 0;
                m_rs   = (m_k > 0) ? (m_k + 2*N + DE) : 2;
            end
        end
        rc = cyc - c0 + 1;
        if (rec_on && rc >= 1 && rc < 64) begin
            rec_clr[rc]   = bus.pe_clr_n;
            rec_en3[rc]   = bus.a_rd_en[3];
            rec_addr3[rc] = int'(bus.a_rd_addr[3*KW +: KW]);
            rec_row[rc]   = int'(bus.res_row);
            rec_valid[rc] = bus.res_valid;
            rec_done[rc]  = bus.done;
            rec_busy[rc]  = bus.busy;
            rec_anyen[rc] = (|bus.a_rd_en) | (|bus.b_rd_en);
        end
    end

    // Start with k for one cycle (or hold start through cycle hold_to), then run len cycles.
    task automatic run(input int k, input int lo, input int hi, input bit noise,
                       input int hold_to, input int len);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.k_len = KW'(k);
        @(posedge clk); #1;
        c0     = cyc;
        rec_on = 1;
        for (int n = 1; n <= len; n++) begin
            bus.res_ready = !(n >= lo && n <= hi);
            bus.start     = (n <= hold_to) || (noise && (n == 3 || n == 10));
            if (noise) bus.k_len = 8'hFF;
            @(posedge clk); #1;
        end
        rec_on        = 0;
        bus.start     = 1'b0;
        bus.res_ready = 1'b1;
    endtask

    function automatic int first_done(input int len);
        for (int i = 1; i <= len; i++) if (rec_done[i]) return i;
        return -1;
    endfunction

    initial begin
        int         cnt;
        logic [31:0] mask;
        n_chk  = 0;
        n_pass = 0;
        rec_on = 0;
        c0     = 0;
        rst_n  = 1'b0;
        bus.start     = 1'b0;
        bus.k_len     = '0;
        bus.res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("hold_rst_clr_n", bus.pe_clr_n, 0);
        chk("hold_rst_row",   bus.res_row,  0);
        rst_n = 1'b1;

        // K=3, ready high, stray start pulses and k_len changes while busy.
        run(3, 0, -1, 1, 0, 22);
        cnt = 0;
        for (int i = 1; i <= 22; i++) if (!rec_clr[i]) cnt++;
        chk("r1_clr_low_cyc1", rec_clr[1], 0);
        chk("r1_clr_low_count", cnt, 1);
        mask = '0;
        for (int i = 1; i <= 22; i++) mask[i] = rec_en3[i];
        chk("r1_a_en3_cycles", mask, 32'h0000_00E0);
        chk("r1_a_addr3_c5", rec_addr3[5], 0);
        chk("r1_a_addr3_c6", rec_addr3[6], 1);
        chk("r1_a_addr3_c7", rec_addr3[7], 2);
        for (int r = 0; r < N; r++) begin
            chk("r1_row_valid", rec_valid[13 + r], 1);
            chk("r1_row_idx",   rec_row[13 + r],   r);
        end
        chk("r1_valid_c12", rec_valid[12], 0);
        chk("r1_done_cycle", first_done(22), 17);
        cnt = 0;
        for (int i = 1; i <= 22; i++) if (rec_done[i]) cnt++;
        chk("r1_done_pulses", cnt, 1);
`ifdef SYSTOLIC_CTRL_PERF_EN
        chk("r1_perf_idle", bus.perf_cycles, 17);
`endif

        // Same run with res_ready low in cycles 15..17 while row 2 is presented.
        run(3, 15, 17, 0, 0, 24);
        chk("r2_row2_c15", rec_row[15], 2);
        chk("r2_row2_c17", rec_row[17], 2);
        chk("r2_row3_c19", rec_row[19], 3);
        chk("r2_done_cycle", first_done(24), 20);

        // K=0: straight from CLEAR to READ.
        run(0, 0, -1, 0, 0, 10);
        cnt = 0;
        for (int i = 1; i <= 10; i++) if (rec_anyen[i]) cnt++;
        chk("r3_no_enables", cnt, 0);
        chk("r3_done_cycle", first_done(10), 6);
        cnt = 0;
        for (int i = 1; i <= 10; i++) if (rec_busy[i]) cnt++;
        chk("r3_busy_count", cnt, 6);
        chk("r3_busy_c1", rec_busy[1], 1);
        chk("r3_busy_c7", rec_busy[7], 0);

        // Reset pulse during FEED at t=2.
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.k_len = 8'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("r4_a_en_t2",   bus.a_rd_en,   4'b0111);
        chk("r4_a_addr_t2", bus.a_rd_addr, 32'h0000_0102);
        #1;
        rst_n = 1'b0;
        #1;
        chk("r4_async_a_en", bus.a_rd_en,  0);
        chk("r4_async_b_en", bus.b_rd_en,  0);
        chk("r4_async_busy", bus.busy,     0);
        chk("r4_async_clr",  bus.pe_clr_n, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Normal run after the reset: K=2 finishes at K+3N+DE = 16.
        run(2, 0, -1, 0, 0, 20);
        chk("r5_clr_low_cyc1", rec_clr[1], 0);
        chk("r5_done_cycle", first_done(20), 16);

        // start held high: two back-to-back K=1 runs with one IDLE cycle between.
        run(1, 0, -1, 0, 31, 34);
        chk("r6_done_first", first_done(34), 15);
        chk("r6_busy_c15", rec_busy[15], 1);
        chk("r6_idle_c16", rec_busy[16], 0);
        chk("r6_busy_c17", rec_busy[17], 1);
        chk("r6_clr_c17",  rec_clr[17],  0);
        chk("r6_done_c31", rec_done[31], 1);
        chk("r6_idle_c32", rec_busy[32], 0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
